// File: rtl/prec_pkg.sv
// Shared types for the precision dispatch scheduler.
//   prec_code_t   - 2-bit per-token precision code from the assignment stage
//   NUM_LANES     - number of compute lanes (INT4, INT8, FP16)
//   lane_of()     - maps a precision code to its lane number
//   sched_state_t - scheduler FSM states
package prec_pkg;

    typedef enum logic [1:0] {
        PREC_INT4 = 2'd0,
        PREC_INT8 = 2'd1,
        PREC_FP16 = 2'd2,
        PREC_RSV  = 2'd3
    } prec_code_t;

    localparam int unsigned NUM_LANES = 3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DISPATCH,
        S_DRAIN,
        S_DONE
    } sched_state_t;

    // The reserved code runs on the FP16 lane.
    function automatic logic [1:0] lane_of(input prec_code_t code);
        case (code)
            PREC_INT4: return 2'd0;
            PREC_INT8: return 2'd1;
            default:   return 2'd2;
        endcase
    endfunction

endpackage

// File: rtl/precision_dispatch_scheduler_if.sv
// Lane-side bus of the precision dispatch scheduler.
//   issue_valid[k] - scheduler offers a token to lane k
//   issue_ready[k] - lane k accepts the offered token
//   issue_idx      - per-lane token index, lane k at [k*IDX_W +: IDX_W]
//   cmpl_valid[k]  - one-cycle completion pulse from lane k, one token each
// master: scheduler side; slave: compute-lane side.
interface precision_dispatch_scheduler_if #(
    parameter int unsigned L = 8
) ();
    import prec_pkg::*;

    localparam int unsigned IDX_W = $clog2(L);

    logic [NUM_LANES-1:0]       issue_valid;
    logic [NUM_LANES-1:0]       issue_ready;
    logic [NUM_LANES*IDX_W-1:0] issue_idx;
    logic [NUM_LANES-1:0]       cmpl_valid;

    modport master (
        output issue_valid,
        output issue_idx,
        input  issue_ready,
        input  cmpl_valid
    );

    modport slave (
        input  issue_valid,
        input  issue_idx,
        output issue_ready,
        output cmpl_valid
    );

endinterface

// File: rtl/lsb_pick.sv
// Lowest-set-bit finder for a W-bit mask.
//   mask   - input bit mask
//   onehot - one-hot of the lowest set bit (zero when mask is zero)
//   idx    - index of the lowest set bit (zero when mask is zero)
//   any    - mask has at least one bit set
module lsb_pick #(
    parameter int unsigned W  = 8,
    parameter int unsigned IW = (W > 1) ? $clog2(W) : 1
) (
    input  logic [W-1:0]  mask,
    output logic [W-1:0]  onehot,
    output logic [IW-1:0] idx,
    output logic          any
);

    always_comb begin
        // Two's-complement trick isolates the lowest set bit.
        onehot = mask & (~mask + W'(1));
        any    = |mask;
        idx    = '0;
        // Scan downwards so the lowest set bit is written last.
        for (int i = int'(W) - 1; i >= 0; i--) begin
            if (mask[i]) idx = IW'(i);
        end
    end

endmodule

// File: rtl/precision_dispatch_scheduler.sv
// Dispatches per-token work onto the INT4 / INT8 / FP16 compute lanes.
//   clk, rst_n - clock and asynchronous active-low reset
//   start      - begin a pass (sampled only when idle)
//   prec_in    - packed 2-bit precision codes, token t at [2t+1:2t]
//   busy       - high whenever a pass is in progress
//   done       - one-cycle pulse at the end of a pass
//   err        - sticky: completion on a lane with nothing outstanding
//   lane       - per-lane issue valid/ready/index and completion pulses
module precision_dispatch_scheduler
    import prec_pkg::*;
#(
    parameter int unsigned L       = 8,
    parameter int unsigned MAX_OUT = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [2*L-1:0]        prec_in,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    precision_dispatch_scheduler_if.master lane
);

    localparam int unsigned IDX_W = $clog2(L);
    localparam int unsigned CNT_W = $clog2(MAX_OUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUT);

    sched_state_t           state_q;
    prec_code_t             snap_q [L];
    // Tokens already issued this pass; all ones outside a pass so nothing is pending.
    logic [L-1:0]           issued_q;
    logic [NUM_LANES-1:0]   issue_valid_q;
    logic [IDX_W-1:0]       issue_idx_q [NUM_LANES];
    logic [CNT_W-1:0]       out_cnt_q [NUM_LANES];
    logic                   busy_q;
    logic                   done_q;
    logic                   err_q;

    logic [L-1:0]           pend [NUM_LANES];
    logic [L-1:0]           pick_oh [NUM_LANES];
    logic [IDX_W-1:0]       pick_idx [NUM_LANES];
    logic [NUM_LANES-1:0]   pick_any;
    logic [NUM_LANES-1:0]   hs;
    logic [NUM_LANES-1:0]   underflow;
    logic [NUM_LANES-1:0]   can_issue;
    logic [CNT_W-1:0]       cnt_d [NUM_LANES];
    logic [L-1:0]           issue_oh;
    logic                   all_cnt_zero;
    logic                   in_pass;
    logic [NUM_LANES*IDX_W-1:0] issue_idx_flat;

    assign in_pass = (state_q == S_DISPATCH) || (state_q == S_DRAIN);

    always_comb begin
        for (int k = 0; k < int'(NUM_LANES); k++) begin
            pend[k] = '0;
            for (int t = 0; t < int'(L); t++) begin
                pend[k][t] = (lane_of(snap_q[t]) == 2'(k)) && !issued_q[t];
            end
        end
    end

    for (genvar k = 0; k < int'(NUM_LANES); k++) begin : g_lane
        lsb_pick #(
            .W (L)
        ) u_pick (
            .mask   (pend[k]),
            .onehot (pick_oh[k]),
            .idx    (pick_idx[k]),
            .any    (pick_any[k])
        );
    end

    always_comb begin
        hs           = '0;
        underflow    = '0;
        can_issue    = '0;
        issue_oh     = '0;
        all_cnt_zero = 1'b1;
        for (int k = 0; k < int'(NUM_LANES); k++) begin
            hs[k]        = issue_valid_q[k] & lane.issue_ready[k];
            underflow[k] = lane.cmpl_valid[k] & ~hs[k] & (out_cnt_q[k] == '0);
            can_issue[k] = in_pass & ~issue_valid_q[k] & pick_any[k] &
                           (out_cnt_q[k] < CNT_MAX);
            // Handshake and completion on the same edge cancel out.
            cnt_d[k] = out_cnt_q[k];
            if (hs[k] && !lane.cmpl_valid[k]) begin
                cnt_d[k] = out_cnt_q[k] + CNT_W'(1);
            end else if (!hs[k] && lane.cmpl_valid[k] && out_cnt_q[k] != '0) begin
                cnt_d[k] = out_cnt_q[k] - CNT_W'(1);
            end
            if (can_issue[k]) issue_oh = issue_oh | pick_oh[k];
            if (cnt_d[k] != '0) all_cnt_zero = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            issued_q      <= '1;
            issue_valid_q <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
            for (int t = 0; t < int'(L); t++) snap_q[t] <= PREC_INT4;
            for (int k = 0; k < int'(NUM_LANES); k++) begin
                issue_idx_q[k] <= '0;
                out_cnt_q[k]   <= '0;
            end
        end else begin
            done_q   <= 1'b0;
            issued_q <= issued_q | issue_oh;
            for (int k = 0; k < int'(NUM_LANES); k++) begin
                out_cnt_q[k] <= cnt_d[k];
                if (hs[k]) begin
                    issue_valid_q[k] <= 1'b0;
                end else if (can_issue[k]) begin
                    issue_valid_q[k] <= 1'b1;
                    issue_idx_q[k]   <= pick_idx[k];
                end
            end
            if (|underflow) err_q <= 1'b1;

            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        for (int t = 0; t < int'(L); t++) begin
                            snap_q[t] <= prec_code_t'(prec_in[2*t +: 2]);
                        end
                        issued_q <= '0;
                        // An underflow on the start edge still wins over the clear.
                        err_q    <= |underflow;
                        busy_q   <= 1'b1;
                        state_q  <= S_DISPATCH;
                    end
                end
                S_DISPATCH: begin
                    if (!(|pick_any) && !(|issue_valid_q)) state_q <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (all_cnt_zero) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        issue_idx_flat = '0;
        for (int k = 0; k < int'(NUM_LANES); k++) begin
            issue_idx_flat[k*IDX_W +: IDX_W] = issue_idx_q[k];
        end
    end

    assign lane.issue_valid = issue_valid_q;
    assign lane.issue_idx   = issue_idx_flat;
    assign busy             = busy_q;
    assign done             = done_q;
    assign err              = err_q;

endmodule

// File: tb/tb_precision_dispatch_scheduler.sv
module tb_precision_dispatch_scheduler;

    localparam int unsigned L       = 8;
    localparam int unsigned MAX_OUT = 2;
    localparam int          IW      = 3;
    // Tokens 0..7 carry codes {0,1,2,3,0,1,2,0}.
    localparam logic [15:0] MIXED   = 16'h24E4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] prec_in = '0;
    logic        busy;
    logic        done;
    logic        err;

    precision_dispatch_scheduler_if #(.L(L)) lane_if ();

    precision_dispatch_scheduler #(
        .L       (L),
        .MAX_OUT (MAX_OUT)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .prec_in (prec_in),
        .busy    (busy),
        .done    (done),
        .err     (err),
        .lane    (lane_if)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int exp0[$];
    int exp1[$];
    int exp2[$];
    int hs_total[3];
    int cmpl_given[3];
    int done_cnt = 0;
    int pass_done0 = 0;
    logic [2:0] hs_now = '0;
    logic [2:0] pipe = '0;
    logic [2:0] man_cmpl = '0;
    logic [2:0] auto_cmpl = '0;
    logic       hold[3];
    int         hold_idx[3];

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    function automatic int idx_of(input int k);
        return int'(lane_if.issue_idx[k*IW +: IW]);
    endfunction

    function automatic int pop_exp(input int k);
        int v;
        v = -1;
        case (k)
            0: if (exp0.size() > 0) v = exp0.pop_front();
            1: if (exp1.size() > 0) v = exp1.pop_front();
            default: if (exp2.size() > 0) v = exp2.pop_front();
        endcase
        return v;
    endfunction

    // Monitor: compares every handshake against the scoreboard and checks hold stability.
    always @(negedge clk) begin
        if (!rst_n) begin
            hs_now = '0;
            for (int k = 0; k < 3; k++) hold[k] = 1'b0;
        end else begin
            if (done) done_cnt++;
            for (int k = 0; k < 3; k++) begin
                if (hold[k]) begin
                    check($sformatf("lane%0d_hold_valid", k), int'(lane_if.issue_valid[k]), 1);
                    check($sformatf("lane%0d_hold_idx", k), idx_of(k), hold_idx[k]);
                end
                hs_now[k] = lane_if.issue_valid[k] & lane_if.issue_ready[k];
                if (hs_now[k]) begin
                    hs_total[k]++;
                    check($sformatf("lane%0d_issue_idx", k), idx_of(k), pop_exp(k));
                end
                hold[k]     = lane_if.issue_valid[k] & ~lane_if.issue_ready[k];
                hold_idx[k] = idx_of(k);
            end
        end
    end

    // Lane model: optional completion two cycles after each handshake, plus manual pulses.
    initial begin
        lane_if.cmpl_valid = '0;
        forever begin
            @(posedge clk);
            #2;
            lane_if.cmpl_valid = (auto_cmpl & pipe) | man_cmpl;
            pipe = rst_n ? hs_now : 3'b000;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_mixed();
        exp0.push_back(0); exp0.push_back(4); exp0.push_back(7);
        exp1.push_back(1); exp1.push_back(5);
        exp2.push_back(2); exp2.push_back(3); exp2.push_back(6);
    endtask

    task automatic pulse_start(input logic [15:0] p);
        pass_done0 = done_cnt;
        prec_in = p;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int bound);
        for (int i = 0; i < bound && done_cnt == pass_done0; i++) tick();
        repeat (3) tick();
        check({name, "_single_done"}, done_cnt - pass_done0, 1);
        check({name, "_busy_after"}, int'(busy), 0);
        check({name, "_err_after"}, int'(err), 0);
        check({name, "_queue_left"}, exp0.size() + exp1.size() + exp2.size(), 0);
    endtask

    task automatic wait_valid(input int k, input int bound);
        for (int i = 0; i < bound && !lane_if.issue_valid[k]; i++) tick();
        check($sformatf("lane%0d_wait_valid", k), int'(lane_if.issue_valid[k]), 1);
    endtask

    // Hand out one completion at a time, only while the lane has work outstanding.
    task automatic drain_lane(input int k, input int bound);
        for (int i = 0; i < bound && done_cnt == pass_done0; i++) begin
            if (hs_total[k] - cmpl_given[k] > 0) begin
                man_cmpl[k] = 1'b1;
                cmpl_given[k]++;
                tick();
                man_cmpl = '0;
            end
            tick();
        end
    endtask

    task automatic clear_counts();
        for (int k = 0; k < 3; k++) begin
            hs_total[k]   = 0;
            cmpl_given[k] = 0;
        end
    endtask

    initial begin
        lane_if.issue_ready = '0;
        clear_counts();
        repeat (3) tick();
        @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_err", int'(err), 0);
        check("rst_valid", int'(lane_if.issue_valid), 0);
        check("rst_idx", int'(lane_if.issue_idx), 0);
        tick();
        rst_n = 1'b1;
        tick();

        // Mixed codes, all ready, completions two cycles after each issue.
        lane_if.issue_ready = 3'b111;
        auto_cmpl = 3'b111;
        push_mixed();
        pulse_start(MIXED);
        @(negedge clk);
        check("t1_busy_after_start", int'(busy), 1);
        check("t1_valid_first_cycle", int'(lane_if.issue_valid), 0);
        @(negedge clk);
        check("t1_valid_second_cycle", int'(lane_if.issue_valid), 7);
        tick();
        wait_done("t1", 100);

        // All FP16, no completions: outstanding limit stalls lane 2.
        auto_cmpl = '0;
        lane_if.issue_ready = 3'b100;
        clear_counts();
        for (int t = 0; t < 8; t++) exp2.push_back(t);
        pulse_start(16'hAAAA);
        repeat (10) tick();
        check("t2_hs_at_limit", hs_total[2], MAX_OUT);
        @(negedge clk);
        check("t2_valid_stalled", int'(lane_if.issue_valid[2]), 0);
        check("t2_busy_stalled", int'(busy), 1);
        tick();
        man_cmpl = 3'b100;
        cmpl_given[2]++;
        tick();
        man_cmpl = '0;
        repeat (4) tick();
        check("t2_hs_after_cmpl", hs_total[2], 3);
        drain_lane(2, 200);
        wait_done("t2", 50);

        // Lane 1 backpressured for several cycles.
        auto_cmpl = 3'b111;
        lane_if.issue_ready = 3'b101;
        push_mixed();
        pulse_start(MIXED);
        repeat (6) tick();
        @(negedge clk);
        check("t3_lane1_waiting", int'(lane_if.issue_valid[1]), 1);
        check("t3_lane1_idx", idx_of(1), 1);
        tick();
        lane_if.issue_ready = 3'b111;
        wait_done("t3", 100);

        // Handshake and completion on the same edge with one outstanding on lane 0.
        auto_cmpl = '0;
        lane_if.issue_ready = '0;
        clear_counts();
        for (int t = 0; t < 8; t++) exp0.push_back(t);
        pulse_start(16'h0000);
        wait_valid(0, 10);
        lane_if.issue_ready = 3'b001;
        tick();
        lane_if.issue_ready = '0;
        wait_valid(0, 10);
        lane_if.issue_ready = 3'b001;
        man_cmpl = 3'b001;
        cmpl_given[0]++;
        tick();
        man_cmpl = '0;
        repeat (8) tick();
        check("t4_hs_after_overlap", hs_total[0], 3);
        check("t4_valid_at_limit", int'(lane_if.issue_valid[0]), 0);
        drain_lane(0, 300);
        wait_done("t4", 50);

        // Completion while idle sets err; next start clears it; start while busy ignored.
        auto_cmpl = 3'b111;
        lane_if.issue_ready = 3'b111;
        man_cmpl = 3'b010;
        tick();
        man_cmpl = '0;
        @(negedge clk);
        check("t5_err_idle_cmpl", int'(err), 1);
        tick();
        push_mixed();
        pulse_start(MIXED);
        @(negedge clk);
        check("t5_err_cleared", int'(err), 0);
        tick();
        repeat (3) tick();
        prec_in = 16'h0000;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("t5", 100);
        repeat (4) tick();
        check("t5_no_extra_done", done_cnt - pass_done0, 1);

        // Asynchronous reset in the middle of dispatch, then a clean pass.
        lane_if.issue_ready = '0;
        push_mixed();
        pulse_start(MIXED);
        repeat (3) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_busy", int'(busy), 0);
        check("t6_rst_valid", int'(lane_if.issue_valid), 0);
        check("t6_rst_idx", int'(lane_if.issue_idx), 0);
        check("t6_rst_done", int'(done), 0);
        check("t6_rst_err", int'(err), 0);
        exp0.delete();
        exp1.delete();
        exp2.delete();
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        lane_if.issue_ready = 3'b111;
        push_mixed();
        pulse_start(MIXED);
        wait_done("t6", 100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
